// File: rtl/romix_pkg.sv
// Shared types and constants for the scrypt ROMix sequencer.
// State encoding plus block geometry used by romix_ctrl.
package romix_pkg;

    localparam int WORD_W = 32;
    localparam int INTEGERIFY_WORD = 48;
    localparam int BLK_WORDS = 64;

    typedef enum logic [2:0] {
        IDLE,
        F_ISS,
        F_WAIT,
        M_RD,
        M_RDW,
        M_ISS,
        M_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/romix_if.sv
// ROMix sequencer bus: job input, DBLMIX_CALC link, scratchpad, result.
// master = sequencer side, slave = environment side.
interface romix_if #(
    parameter int BLOCK_SIZE = 256,
    parameter int N_LOG2 = 10
);
    localparam int BW = BLOCK_SIZE * 8;

    logic              job_vld;
    logic              job_rdy;
    logic [BW-1:0]     job_x;
    logic [BW-1:0]     job_z;
    logic              mix_in_vld;
    logic              mix_in_rdy;
    logic [BW-1:0]     mix_x;
    logic [BW-1:0]     mix_z;
    logic              mix_out_vld;
    logic              mix_out_rdy;
    logic [BW-1:0]     mix_x_res;
    logic [BW-1:0]     mix_z_res;
    logic              ram_we;
    logic [N_LOG2-1:0] ram_waddr;
    logic [BW-1:0]     ram_wdata_x;
    logic [BW-1:0]     ram_wdata_z;
    logic              ram_re;
    logic [N_LOG2-1:0] ram_raddr_x;
    logic [N_LOG2-1:0] ram_raddr_z;
    logic [BW-1:0]     ram_rdata_x;
    logic [BW-1:0]     ram_rdata_z;
    logic              res_vld;
    logic              res_rdy;
    logic [BW-1:0]     res_x;
    logic [BW-1:0]     res_z;

    modport master (
        input  job_vld, job_x, job_z,
        output job_rdy,
        output mix_in_vld, mix_x, mix_z,
        input  mix_in_rdy,
        input  mix_out_vld, mix_x_res, mix_z_res,
        output mix_out_rdy,
        output ram_we, ram_waddr, ram_wdata_x, ram_wdata_z,
        output ram_re, ram_raddr_x, ram_raddr_z,
        input  ram_rdata_x, ram_rdata_z,
        output res_vld, res_x, res_z,
        input  res_rdy
    );

    modport slave (
        output job_vld, job_x, job_z,
        input  job_rdy,
        input  mix_in_vld, mix_x, mix_z,
        output mix_in_rdy,
        output mix_out_vld, mix_x_res, mix_z_res,
        input  mix_out_rdy,
        input  ram_we, ram_waddr, ram_wdata_x, ram_wdata_z,
        input  ram_re, ram_raddr_x, ram_raddr_z,
        output ram_rdata_x, ram_rdata_z,
        input  res_vld, res_x, res_z,
        output res_rdy
    );

endinterface

// File: rtl/romix_ctrl.sv
// Scrypt ROMix sequencer for two lanes (x/sha, z/cha) feeding DBLMIX_CALC.
// Optional ROMIX_CYCLE_CNT_EN adds a saturating busy_cycles counter.
module romix_ctrl
    import romix_pkg::*;
#(
    parameter int BLOCK_SIZE = 256,
    parameter int N_LOG2 = 10,
    parameter int RAM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    romix_if.master    bus
`ifdef ROMIX_CYCLE_CNT_EN
    ,
    output logic [31:0] busy_cycles
`endif
);

    localparam int BW = BLOCK_SIZE * 8;
    localparam int WW = $clog2(RAM_LAT + 1);
    localparam int JLO = INTEGERIFY_WORD * WORD_W;
    localparam logic [N_LOG2-1:0] LAST = '1;

    state_t state, nxt;
    logic [N_LOG2-1:0] cnt;
    logic [WW-1:0] wait_cnt;
    logic [BW-1:0] x_x, x_z;
    logic [BW-1:0] op_x, op_z;
    logic rd_done;

    assign rd_done = (wait_cnt == WW'(1));

    always_comb begin
        nxt = state;
        bus.job_rdy = 1'b0;
        bus.mix_in_vld = 1'b0;
        bus.mix_out_rdy = 1'b0;
        bus.ram_we = 1'b0;
        bus.ram_re = 1'b0;
        bus.res_vld = 1'b0;
        unique case (state)
            IDLE: begin
                bus.job_rdy = 1'b1;
                if (bus.job_vld) nxt = F_ISS;
            end
            F_ISS: begin
                bus.mix_in_vld = 1'b1;
                // one V write per i, tied to the accepted BlockMix issue
                bus.ram_we = bus.mix_in_rdy;
                if (bus.mix_in_rdy) nxt = F_WAIT;
            end
            F_WAIT: begin
                bus.mix_out_rdy = 1'b1;
                if (bus.mix_out_vld)
                    nxt = (cnt == LAST) ? M_RD : F_ISS;
            end
            M_RD: begin
                bus.ram_re = 1'b1;
                nxt = M_RDW;
            end
            M_RDW: begin
                if (rd_done) nxt = M_ISS;
            end
            M_ISS: begin
                bus.mix_in_vld = 1'b1;
                if (bus.mix_in_rdy) nxt = M_WAIT;
            end
            M_WAIT: begin
                bus.mix_out_rdy = 1'b1;
                if (bus.mix_out_vld)
                    nxt = (cnt == LAST) ? DONE : M_RD;
            end
            DONE: begin
                bus.res_vld = 1'b1;
                if (bus.res_rdy) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            wait_cnt <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.job_vld)
                cnt <= '0;
            if (state == F_WAIT && bus.mix_out_vld)
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (state == M_WAIT && bus.mix_out_vld && cnt != LAST)
                cnt <= cnt + 1'b1;
            if (state == M_RD)
                wait_cnt <= WW'(RAM_LAT);
            if (state == M_RDW)
                wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // op_* is the BlockMix operand; it only changes outside the issue states
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.job_vld) begin
            x_x <= bus.job_x;
            x_z <= bus.job_z;
            op_x <= bus.job_x;
            op_z <= bus.job_z;
        end
        if ((state == F_WAIT || state == M_WAIT) && bus.mix_out_vld) begin
            x_x <= bus.mix_x_res;
            x_z <= bus.mix_z_res;
            op_x <= bus.mix_x_res;
            op_z <= bus.mix_z_res;
        end
        if (state == M_RDW && rd_done) begin
            op_x <= x_x ^ bus.ram_rdata_x;
            op_z <= x_z ^ bus.ram_rdata_z;
        end
    end

    assign bus.mix_x = op_x;
    assign bus.mix_z = op_z;
    assign bus.ram_waddr = cnt;
    assign bus.ram_wdata_x = x_x;
    assign bus.ram_wdata_z = x_z;
    assign bus.ram_raddr_x = x_x[JLO +: N_LOG2];
    assign bus.ram_raddr_z = x_z[JLO +: N_LOG2];
    assign bus.res_x = x_x;
    assign bus.res_z = x_z;

`ifdef ROMIX_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cycles <= '0;
        end else if (state == IDLE) begin
            if (bus.job_vld) busy_cycles <= '0;
        end else if (state != DONE && busy_cycles != '1) begin
            busy_cycles <= busy_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_romix_ctrl.sv
// Bench for romix_ctrl: XOR-stub BlockMix, latency-accurate RAM, ROMix model.
// With ROMIX_CYCLE_CNT_EN the RAM latency is 3 and busy_cycles is checked.
module tb_romix_ctrl;
    import romix_pkg::*;

    localparam int BLOCK_SIZE = 256;
    localparam int BW = BLOCK_SIZE * 8;
    localparam int N_LOG2 = 1;
    localparam int N = 2 ** N_LOG2;
`ifdef ROMIX_CYCLE_CNT_EN
    localparam int RAM_LAT = 3;
`else
    localparam int RAM_LAT = 1;
`endif

    typedef logic [BW-1:0] blk_t;
    typedef logic [N_LOG2-1:0] idx_t;
    localparam blk_t C = {64{32'h1}};
    localparam blk_t POISON = {64{32'hdeadbeef}};

    typedef struct {
        blk_t jx;
        blk_t jz;
        blk_t ex;
        blk_t ez;
        int   stall_in;
        int   stall_res;
        bit   diverge;
    } vec_t;

    typedef struct {
        idx_t a;
        blk_t dx;
        blk_t dz;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    romix_if #(.BLOCK_SIZE(BLOCK_SIZE), .N_LOG2(N_LOG2)) bus();

`ifdef ROMIX_CYCLE_CNT_EN
    logic [31:0] busy;
`endif

    romix_ctrl #(
        .BLOCK_SIZE(BLOCK_SIZE),
        .N_LOG2(N_LOG2),
        .RAM_LAT(RAM_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ROMIX_CYCLE_CNT_EN
        ,
        .busy_cycles(busy)
`endif
    );

    // BlockMix stub: one cycle, one transaction in flight
    logic tb_in_rdy;
    logic out_pend;
    blk_t out_x, out_z;
    assign bus.mix_in_rdy = tb_in_rdy & ~out_pend;
    assign bus.mix_out_vld = out_pend;
    assign bus.mix_x_res = out_x;
    assign bus.mix_z_res = out_z;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pend <= 1'b0;
        end else begin
            if (bus.mix_out_vld && bus.mix_out_rdy) out_pend <= 1'b0;
            if (bus.mix_in_vld && bus.mix_in_rdy) begin
                out_pend <= 1'b1;
                out_x <= bus.mix_x ^ C;
                out_z <= bus.mix_z ^ C;
            end
        end
    end

    // Scratchpad; data is only valid exactly RAM_LAT cycles after ram_re
    blk_t mem_x [N];
    blk_t mem_z [N];
    blk_t px [RAM_LAT];
    blk_t pz [RAM_LAT];
    assign bus.ram_rdata_x = px[RAM_LAT-1];
    assign bus.ram_rdata_z = pz[RAM_LAT-1];

    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem_x[bus.ram_waddr] <= bus.ram_wdata_x;
            mem_z[bus.ram_waddr] <= bus.ram_wdata_z;
        end
        px[0] <= bus.ram_re ? mem_x[bus.ram_raddr_x] : POISON;
        pz[0] <= bus.ram_re ? mem_z[bus.ram_raddr_z] : POISON;
        for (int k = 1; k < RAM_LAT; k++) begin
            px[k] <= px[k-1];
            pz[k] <= pz[k-1];
        end
    end

    wr_t wr_q[$];
    idx_t rdx_q[$];
    idx_t rdz_q[$];
    int meas;

    always @(posedge clk) begin
        if (bus.ram_we)
            wr_q.push_back('{bus.ram_waddr, bus.ram_wdata_x, bus.ram_wdata_z});
        if (bus.ram_re) begin
            rdx_q.push_back(bus.ram_raddr_x);
            rdz_q.push_back(bus.ram_raddr_z);
        end
        if (bus.job_vld && bus.job_rdy) meas <= 0;
        else if (!bus.job_rdy && !bus.res_vld) meas <= meas + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input blk_t act, input blk_t exp);
        int w;
        checks++;
        if (act !== exp) begin
            errors++;
            w = 0;
            while (w < 63 && act[w*32 +: 32] === exp[w*32 +: 32]) w++;
            $display("FAIL %s word%0d act=%h exp=%h", nm, w,
                     act[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    function automatic blk_t bm(input blk_t b);
        return b ^ C;
    endfunction

    task automatic model(input blk_t x0, output blk_t res,
                         output blk_t v[N], output idx_t j[N]);
        blk_t x;
        logic [31:0] w;
        x = x0;
        for (int i = 0; i < N; i++) begin
            v[i] = x;
            x = bm(x);
        end
        for (int k = 0; k < N; k++) begin
            w = x[48*32 +: 32];
            j[k] = idx_t'(w % 32'(N));
            x = bm(x ^ v[j[k]]);
        end
        res = x;
    endtask

    function automatic blk_t rnd_blk();
        blk_t b;
        for (int w = 0; w < 64; w++) b[w*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic run_job(input vec_t t);
        blk_t ex, ez;
        blk_t vx[N], vz[N];
        idx_t jx[N], jz[N];
        int n;
        model(t.jx, ex, vx, jx);
        model(t.jz, ez, vz, jz);
        wr_q.delete();
        rdx_q.delete();
        rdz_q.delete();
        @(negedge clk);
        chk("idle_rdy", bus.job_rdy, 1);
        bus.job_x = t.jx;
        bus.job_z = t.jz;
        bus.job_vld = 1'b1;
        bus.res_rdy = 1'b0;
        tb_in_rdy = (t.stall_in == 0);
        @(negedge clk);
        bus.job_vld = 1'b0;
        chk("job_rdy_busy", bus.job_rdy, 0);
        for (int k = 0; k < t.stall_in; k++) begin
            chk("stall_vld", bus.mix_in_vld, 1);
            chk_blk("stall_mix_x", bus.mix_x, t.jx);
            chk("stall_we", bus.ram_we, 0);
            @(negedge clk);
        end
        tb_in_rdy = 1'b1;
        n = 0;
        while (!bus.res_vld && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("res_timeout", bus.res_vld, 1);
        if (!bus.res_vld) return;
`ifdef ROMIX_CYCLE_CNT_EN
        chk("busy_cycles", busy, 64'(meas));
`endif
        for (int k = 0; k < t.stall_res; k++) begin
            chk("hold_vld", bus.res_vld, 1);
            chk("hold_job_rdy", bus.job_rdy, 0);
            chk_blk("hold_res_x", bus.res_x, ex);
            @(negedge clk);
        end
        chk_blk("res_x", bus.res_x, t.ex);
        chk_blk("res_z", bus.res_z, t.ez);
        bus.res_rdy = 1'b1;
        @(negedge clk);
        bus.res_rdy = 1'b0;
        chk("post_job_rdy", bus.job_rdy, 1);
        chk("post_res_vld", bus.res_vld, 0);
        chk("n_writes", wr_q.size(), N);
        chk("n_reads", rdx_q.size(), N);
        for (int i = 0; i < N && i < wr_q.size(); i++) begin
            chk("waddr", wr_q[i].a, i);
            chk_blk("wdata_x", wr_q[i].dx, vx[i]);
            chk_blk("wdata_z", wr_q[i].dz, vz[i]);
        end
        for (int k = 0; k < N && k < rdx_q.size(); k++) begin
            chk("raddr_x", rdx_q[k], jx[k]);
            chk("raddr_z", rdz_q[k], jz[k]);
        end
        if (t.diverge && rdx_q.size() > 0)
            chk("lanes_diverge", rdx_q[0] != rdz_q[0], 1);
    endtask

    vec_t vecs[$];
    vec_t v;
    blk_t dummy_v[N];
    idx_t dummy_j[N];

    initial begin
        bus.job_vld = 1'b0;
        bus.job_x = '0;
        bus.job_z = '0;
        bus.res_rdy = 1'b0;
        tb_in_rdy = 1'b1;

        vecs.push_back('{jx: '0, jz: '0, ex: C, ez: C,
                         stall_in: 0, stall_res: 0, diverge: 0});
        v = '{jx: rnd_blk(), jz: rnd_blk(), ex: '0, ez: '0,
              stall_in: 5, stall_res: 0, diverge: 0};
        vecs.push_back(v);
        v = '{jx: rnd_blk(), jz: rnd_blk(), ex: '0, ez: '0,
              stall_in: 0, stall_res: 0, diverge: 1};
        v.jx[48*32 +: 32] = 32'd0;
        v.jz[48*32 +: 32] = 32'd1;
        vecs.push_back(v);
        v = '{jx: rnd_blk(), jz: rnd_blk(), ex: '0, ez: '0,
              stall_in: 0, stall_res: 10, diverge: 0};
        vecs.push_back(v);
        for (int r = 0; r < 6; r++) begin
            v = '{jx: rnd_blk(), jz: rnd_blk(), ex: '0, ez: '0,
                  stall_in: 0, stall_res: 0, diverge: 0};
            vecs.push_back(v);
        end
        for (int i = 1; i < vecs.size(); i++) begin
            model(vecs[i].jx, vecs[i].ex, dummy_v, dummy_j);
            model(vecs[i].jz, vecs[i].ez, dummy_v, dummy_j);
        end

        repeat (2) @(negedge clk);
        chk("rst_job_rdy", bus.job_rdy, 1);
        chk("rst_mix_in_vld", bus.mix_in_vld, 0);
        chk("rst_mix_out_rdy", bus.mix_out_rdy, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_re", bus.ram_re, 0);
        chk("rst_res_vld", bus.res_vld, 0);
`ifdef ROMIX_CYCLE_CNT_EN
        chk("rst_busy", busy, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_job(vecs[i]);

        // reset pulse in the middle of the mix loop
        begin
            int n;
            @(negedge clk);
            bus.job_x = '0;
            bus.job_z = '0;
            bus.job_vld = 1'b1;
            rdx_q.delete();
            @(negedge clk);
            bus.job_vld = 1'b0;
            n = 0;
            while (!(bus.mix_out_rdy && rdx_q.size() > 0) && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("reach_m_wait", bus.mix_out_rdy && rdx_q.size() > 0, 1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            chk("arst_mix_in_vld", bus.mix_in_vld, 0);
            chk("arst_mix_out_rdy", bus.mix_out_rdy, 0);
            chk("arst_ram_we", bus.ram_we, 0);
            chk("arst_ram_re", bus.ram_re, 0);
            chk("arst_res_vld", bus.res_vld, 0);
            chk("arst_job_rdy", bus.job_rdy, 1);
            @(negedge clk);
            rst = 1'b0;
        end
        run_job(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
